// File: rtl/param_rr_stream_mux.sv
// Registered N-channel valid/ready stream mux with runtime choice of manual
// select or round-robin arbitration; one output word register.

module param_rr_stream_mux_lane #(
   parameter int SEL_W = 2,
   parameter int IDX   = 0
) (
   input  logic [SEL_W-1:0] grant,
   input  logic             take,
   output logic             ready
);
   assign ready = take && (grant == SEL_W'(IDX));
endmodule

module param_rr_stream_mux #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_ch
);
   logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
   logic [SEL_W-1:0]             last_grant, rr_grant, grant;
   logic                         rr_vld, man_vld, grant_vld, load_en, take;
   logic [WIDTH-1:0]             grant_data;
   int                           rr_best, rr_dist;

   assign ch_data = in_data;
   assign load_en = !out_valid || out_ready;

   // Round-robin: the valid channel with the smallest distance after
   // last_grant (wrapping) wins, so the previous winner has lowest priority.
   always_comb begin
      rr_grant = '0;
      rr_vld   = 1'b0;
      rr_best  = NUM_CH;
      rr_dist  = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         rr_dist = (i - int'(last_grant) - 1 + 2 * NUM_CH) % NUM_CH;
         if (in_valid[i] && rr_dist < rr_best) begin
            rr_best  = rr_dist;
            rr_grant = SEL_W'(i);
            rr_vld   = 1'b1;
         end
      end
   end

   // Out-of-range sel matches no channel and therefore never grants.
   always_comb begin
      man_vld = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (sel == SEL_W'(i)) man_vld = in_valid[i];
   end

   assign grant     = mode ? rr_grant : sel;
   assign grant_vld = mode ? rr_vld : man_vld;
   assign take      = load_en && grant_vld && !rst;

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (grant == SEL_W'(i)) grant_data = ch_data[i];
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      param_rr_stream_mux_lane #(.SEL_W(SEL_W), .IDX(g)) u_lane (
         .grant (grant),
         .take  (take),
         .ready (in_ready[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         last_grant <= SEL_W'(NUM_CH - 1);
      end else if (load_en) begin
         out_valid <= grant_vld;
         if (grant_vld) begin
            out_data   <= grant_data;
            out_ch     <= grant;
            last_grant <= grant;
         end
      end
   end
endmodule

// File: doc/param_rr_stream_mux.md
Name: param_rr_stream_mux

Overview:
- Parametrised, registered N-channel, W-bit stream multiplexer with valid/ready handshaking on every input and on the output.
- Channel choice is either manual (sel port) or fair round-robin among valid channels, picked at runtime by the mode port.
- Sits between multiple producer blocks and a single shared consumer.
- Generalises the 1-bit 4:1 gate-level mux in width, channel count, arbitration mode and flow control.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must equal ceil(log2(NUM_CH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- mode  input  1  0 = manual select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_ch  output  SEL_W  channel index of the word in out_data.

Behaviour:
- Reset (async, takes effect immediately):
  - out_data=0, out_valid=0, out_ch=0.
  - Round-robin pointer last_grant = NUM_CH-1, so channel 0 has first priority.
  - in_ready all 0 while rst=1.
- load_en = !out_valid || out_ready (output register empty or being drained this cycle).
- Grant (combinational):
  - mode=0: grant=sel, grant_vld = in_valid[sel]. If sel >= NUM_CH, grant_vld=0.
  - mode=1: search channels starting at last_grant+1 with wrap-around at NUM_CH-1 -> 0. grant = first channel with in_valid set; grant_vld=1 if any in_valid is set.
- in_ready[i] = load_en && grant_vld && (grant==i) && !rst. At most one in_ready is high per cycle.
- On a clock edge with load_en=1:
  - out_valid <= grant_vld.
  - If grant_vld: out_data <= granted slice, out_ch <= grant.
  - If !grant_vld: out_data and out_ch hold their previous values.
- On a clock edge with load_en=0: out_data, out_valid and out_ch hold.
  - out_data must stay stable while out_valid && !out_ready.
- last_grant <= grant on every accepted transfer (in_valid[grant] && in_ready[grant]), in either mode. Otherwise it is unchanged.
- Latency and throughput:
  - Input acceptance to out_valid is 1 cycle.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- mode/sel changes only affect the next grant decision. The word already held in the output register is never altered.
- Simultaneous drain and load (out_valid && out_ready && grant_vld): new word replaces old in the same edge with no bubble.
- Producer hold rule: a producer whose in_valid is high and not yet accepted keeps in_data stable. The block does not check this rule.
- Reset mid-transfer: the held word is discarded and arbitration restarts at channel 0.
- Implementation is RTL, synchronous except for the reset. The round-robin search is a rotate/priority loop over NUM_CH.

Test Plan:
- Reset: stream running, assert rst between edges -> out_valid=0, out_data=0, out_ch=0, in_ready=0000 immediately. After release with all valid in mode=1, the first output is from ch0.
- Manual: mode=0, sel=2, in_valid=0100, ch2 data=0xA5, out_ready=1 -> in_ready=0100. Next cycle out_valid=1, out_data=0xA5, out_ch=2.
- Round-robin fairness: mode=1, all valid, ch i data=0x10+i, out_ready=1 -> out_data on consecutive cycles 0x10, 0x11, 0x12, 0x13, 0x10.
- Sparse round-robin: in_valid=1010 constant -> out_ch sequence 1, 3, 1, 3. Channels 0 and 2 never see in_ready.
- Backpressure: out_valid=1 with 0x11, out_ready=0 for 3 cycles -> out_data stays 0x11 and in_ready=0000 throughout. Raise out_ready -> 0x12 loaded on the same edge, no idle cycle.
- Invalid select: NUM_CH=3, SEL_W=2, mode=0, sel=3, all valid -> in_ready=000. out_valid drops to 0 after the pending word drains.
